// File: rtl/skip_table_writer.sv
// Skip-table writer: turns LOAD / INVALIDATE / CLEAR_ALL commands into
// single-cycle table writes and keeps a shadow map of each entry's valid bit.
module skip_table_writer #(
  parameter int unsigned SKIP_TABLE_SIZE      = 16,
  parameter int unsigned SKIP_TABLE_BLOCK_IDX = 1
) (
  input  logic                                 ClockIn,
  input  logic                                 ResetIn,
  input  logic                                 CmdValidIn,
  output logic                                 CmdReadyOut,
  input  logic [1:0]                           CmdOpIn,
  input  logic [$clog2(SKIP_TABLE_SIZE)-1:0]   CmdIdxIn,
  input  logic [31:0]                          CmdPCIn,
  output logic                                 WriteEnOut,
  output logic [31:0]                          WriteAddressOut,
  output logic [31:0]                          WriteDataOut,
  output logic                                 BusyOut,
  output logic                                 DoneOut,
  output logic                                 ErrorOut,
  output logic [SKIP_TABLE_SIZE-1:0]           ValidMapOut
);

  localparam int unsigned IW = $clog2(SKIP_TABLE_SIZE);

  localparam logic [31:0] BLK_BASE  = 32'(SKIP_TABLE_BLOCK_IDX) << (IW + 2);
  localparam logic [IW:0] CLR_LAST  = {1'b0, {IW{1'b1}}};
  localparam logic [IW:0] CLR_END   = {1'b1, {IW{1'b0}}};
  localparam logic [1:0]  OFF_PC    = 2'd0;
  localparam logic [1:0]  OFF_VALID = 2'd1;

  typedef enum logic [2:0] {
    IDLE,
    WR_INVAL,
    WR_PC,
    WR_VALID,
    CLEAR
  } state_t;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_INVAL = 2'd1,
    OP_CLEAR = 2'd2,
    OP_RSVD  = 2'd3
  } op_t;

  state_t        state;
  op_t           op_q;
  logic [IW-1:0] idx_q;
  logic [31:0]   pc_q;
  logic [IW:0]   clr_cnt;

  function automatic logic [31:0] entry_addr(input logic [IW-1:0] idx,
                                             input logic [1:0]    off);
    return BLK_BASE | {{(30 - IW){1'b0}}, idx, off};
  endfunction

  assign CmdReadyOut = (state == IDLE) && !ResetIn;
  assign BusyOut     = (state != IDLE);

  // The state names the write currently on the bus; the edge that enters a
  // state registers that state's write, so outputs stay purely registered.
  always_ff @(posedge ClockIn) begin
    if (ResetIn) begin
      state           <= IDLE;
      op_q            <= OP_LOAD;
      idx_q           <= '0;
      pc_q            <= '0;
      clr_cnt         <= '0;
      WriteEnOut      <= 1'b0;
      WriteAddressOut <= '0;
      WriteDataOut    <= '0;
      DoneOut         <= 1'b0;
      ErrorOut        <= 1'b0;
      ValidMapOut     <= '0;
    end else begin
      WriteEnOut      <= 1'b0;
      WriteAddressOut <= '0;
      WriteDataOut    <= '0;
      DoneOut         <= 1'b0;

      unique case (state)
        IDLE: begin
          if (CmdValidIn && CmdReadyOut) begin
            op_q  <= op_t'(CmdOpIn);
            idx_q <= CmdIdxIn;
            pc_q  <= CmdPCIn;
            unique case (op_t'(CmdOpIn))
              OP_LOAD, OP_INVAL: begin
                WriteEnOut            <= 1'b1;
                WriteAddressOut       <= entry_addr(CmdIdxIn, OFF_VALID);
                WriteDataOut          <= '0;
                ValidMapOut[CmdIdxIn] <= 1'b0;
                DoneOut               <= (op_t'(CmdOpIn) == OP_INVAL);
                state                 <= WR_INVAL;
              end
              OP_CLEAR: begin
                WriteEnOut      <= 1'b1;
                WriteAddressOut <= entry_addr('0, OFF_VALID);
                WriteDataOut    <= '0;
                ValidMapOut[0]  <= 1'b0;
                clr_cnt         <= {{IW{1'b0}}, 1'b1};
                state           <= CLEAR;
              end
              default: begin
                // Reserved opcode: one busy cycle with no write, then idle.
                ErrorOut <= 1'b1;
                DoneOut  <= 1'b1;
                state    <= WR_INVAL;
              end
            endcase
          end
        end

        WR_INVAL: begin
          if (op_q == OP_LOAD) begin
            WriteEnOut      <= 1'b1;
            WriteAddressOut <= entry_addr(idx_q, OFF_PC);
            WriteDataOut    <= pc_q;
            state           <= WR_PC;
          end else begin
            state <= IDLE;
          end
        end

        WR_PC: begin
          WriteEnOut         <= 1'b1;
          WriteAddressOut    <= entry_addr(idx_q, OFF_VALID);
          WriteDataOut       <= 32'h8000_0000;
          ValidMapOut[idx_q] <= 1'b1;
          DoneOut            <= 1'b1;
          state              <= WR_VALID;
        end

        WR_VALID: begin
          state <= IDLE;
        end

        CLEAR: begin
          if (clr_cnt == CLR_END) begin
            clr_cnt <= '0;
            state   <= IDLE;
          end else begin
            WriteEnOut                  <= 1'b1;
            WriteAddressOut             <= entry_addr(clr_cnt[IW-1:0], OFF_VALID);
            WriteDataOut                <= '0;
            ValidMapOut[clr_cnt[IW-1:0]] <= 1'b0;
            DoneOut                     <= (clr_cnt == CLR_LAST);
            clr_cnt                     <= clr_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_skip_table_writer.sv
// Bench for skip_table_writer: directed vectors plus random commands checked
// against a command-level model of the writes, valid map and error flag.
module tb_skip_table_writer;

  localparam int unsigned SIZE = 16;
  localparam int unsigned BLK  = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_idx;
  logic [31:0] cmd_pc;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] vmap;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  skip_table_writer #(
    .SKIP_TABLE_SIZE     (SIZE),
    .SKIP_TABLE_BLOCK_IDX(BLK)
  ) dut (
    .ClockIn        (clk),
    .ResetIn        (rst),
    .CmdValidIn     (cmd_valid),
    .CmdReadyOut    (cmd_ready),
    .CmdOpIn        (cmd_op),
    .CmdIdxIn       (cmd_idx),
    .CmdPCIn        (cmd_pc),
    .WriteEnOut     (we),
    .WriteAddressOut(waddr),
    .WriteDataOut   (wdata),
    .BusyOut        (busy),
    .DoneOut        (done),
    .ErrorOut       (err),
    .ValidMapOut    (vmap)
  );

  // Command-level reference model
  logic [15:0] m_map;
  logic        m_err;
  logic [31:0] e_addr[$];
  logic [31:0] e_data[$];

  function automatic logic [31:0] ent_addr(int idx, int off);
    return 32'(BLK * SIZE * 4 + idx * 4 + off);
  endfunction

  function automatic void model_cmd(int op, int idx, logic [31:0] pc);
    e_addr.delete();
    e_data.delete();
    case (op)
      0: begin
        e_addr.push_back(ent_addr(idx, 1)); e_data.push_back(32'h0);
        e_addr.push_back(ent_addr(idx, 0)); e_data.push_back(pc);
        e_addr.push_back(ent_addr(idx, 1)); e_data.push_back(32'h8000_0000);
        m_map[idx] = 1'b1;
      end
      1: begin
        e_addr.push_back(ent_addr(idx, 1)); e_data.push_back(32'h0);
        m_map[idx] = 1'b0;
      end
      2: begin
        for (int i = 0; i < int'(SIZE); i++) begin
          e_addr.push_back(ent_addr(i, 1)); e_data.push_back(32'h0);
        end
        m_map = '0;
      end
      default: m_err = 1'b1;
    endcase
  endfunction

  // Per-cycle observations after the acceptance edge (index 1 = cycle T+1)
  logic        ob_we[0:31];
  logic [31:0] ob_addr[0:31];
  logic [31:0] ob_data[0:31];
  logic        ob_done[0:31];
  logic        ob_ready[0:31];
  logic        ob_busy[0:31];
  logic        acc_timeout;

  task automatic run_cmd(input logic [1:0] op, input int idx, input logic [31:0] pc,
                         input int ncyc);
    cmd_op      = op;
    cmd_idx     = 4'(idx);
    cmd_pc      = pc;
    cmd_valid   = 1'b1;
    acc_timeout = 1'b1;
    for (int w = 0; w < 50; w++) begin
      if (cmd_ready) begin
        acc_timeout = 1'b0;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      cmd_valid   = 1'b0;
      ob_we[k]    = we;
      ob_addr[k]  = waddr;
      ob_data[k]  = wdata;
      ob_done[k]  = done;
      ob_ready[k] = cmd_ready;
      ob_busy[k]  = busy;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_idx = '0; cmd_pc = '0;
    m_map = '0; m_err = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready_low got=%b exp=0", cmd_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({cmd_ready, we, waddr, wdata, done, busy, err, vmap} !==
        {1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL reset_state got rdy=%b we=%b a=%h d=%h done=%b busy=%b err=%b map=%h exp rdy=1 rest 0",
               cmd_ready, we, waddr, wdata, done, busy, err, vmap);
    end
  endtask

  task automatic test_load_invalidate;
    logic [65:0] exp_w[1:3];
    model_cmd(0, 3, 32'h0000_1000);
    run_cmd(2'd0, 3, 32'h0000_1000, 4);
    exp_w[1] = {1'b1, 32'h4D, 32'h0, 1'b0};
    exp_w[2] = {1'b1, 32'h4C, 32'h1000, 1'b0};
    exp_w[3] = {1'b1, 32'h4D, 32'h8000_0000, 1'b1};
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if ({ob_we[k], ob_addr[k], ob_data[k], ob_done[k]} !== exp_w[k]) begin
        errors++;
        $display("FAIL load_write k=%0d got we=%b a=%h d=%h done=%b exp %h",
                 k, ob_we[k], ob_addr[k], ob_data[k], ob_done[k], exp_w[k]);
      end
    end
    checks++;
    if ({ob_ready[4], ob_we[4], ob_done[4]} !== 3'b100) begin
      errors++; $display("FAIL load_ready_t4 got rdy=%b we=%b done=%b exp 1 0 0",
                         ob_ready[4], ob_we[4], ob_done[4]);
    end
    checks++;
    if (vmap !== 16'h0008) begin
      errors++; $display("FAIL load_map got=%h exp=0008", vmap);
    end

    model_cmd(1, 3, 32'h0);
    run_cmd(2'd1, 3, 32'hDEAD_BEEF, 2);
    checks++;
    if ({ob_we[1], ob_addr[1], ob_data[1], ob_done[1]} !== {1'b1, 32'h4D, 32'h0, 1'b1}) begin
      errors++; $display("FAIL inval_write got we=%b a=%h d=%h done=%b exp 1 4d 0 1",
                         ob_we[1], ob_addr[1], ob_data[1], ob_done[1]);
    end
    checks++;
    if ({ob_ready[2], ob_we[2], vmap} !== {1'b1, 1'b0, 16'h0000}) begin
      errors++; $display("FAIL inval_after got rdy=%b we=%b map=%h exp 1 0 0000",
                         ob_ready[2], ob_we[2], vmap);
    end
  endtask

  task automatic test_clear_all;
    model_cmd(0, 0, 32'h0000_0100);
    run_cmd(2'd0, 0, 32'h0000_0100, 4);
    model_cmd(0, 15, 32'h0000_0F00);
    run_cmd(2'd0, 15, 32'h0000_0F00, 4);
    checks++;
    if (vmap !== 16'h8001) begin
      errors++; $display("FAIL clear_pre_map got=%h exp=8001", vmap);
    end
    model_cmd(2, 7, 32'h0);
    run_cmd(2'd2, 7, 32'h1234_5678, 18);
    for (int k = 1; k <= 16; k++) begin
      checks++;
      if ({ob_we[k], ob_addr[k], ob_data[k], ob_done[k], ob_busy[k]} !==
          {1'b1, 32'h41 + 32'(4 * (k - 1)), 32'h0, (k == 16), 1'b1}) begin
        errors++;
        $display("FAIL clear_write k=%0d got we=%b a=%h d=%h done=%b busy=%b exp a=%h",
                 k, ob_we[k], ob_addr[k], ob_data[k], ob_done[k], ob_busy[k],
                 32'h41 + 32'(4 * (k - 1)));
      end
    end
    checks++;
    if ({ob_we[17], ob_done[17], ob_ready[17], ob_we[18], vmap} !== {4'b0010, 16'h0}) begin
      errors++; $display("FAIL clear_end got we17=%b done17=%b rdy17=%b we18=%b map=%h exp 0 0 1 0 0000",
                         ob_we[17], ob_done[17], ob_ready[17], ob_we[18], vmap);
    end
  endtask

  task automatic test_reserved;
    model_cmd(3, 5, 32'h0);
    run_cmd(2'd3, 5, 32'hFFFF_FFFF, 3);
    checks++;
    if ({ob_we[1], ob_done[1], ob_ready[1], ob_we[2], ob_done[2], ob_ready[2]} !== 6'b010001) begin
      errors++; $display("FAIL rsvd_timing got we=%b%b done=%b%b rdy=%b%b exp we=00 done=10 rdy=01",
                         ob_we[1], ob_we[2], ob_done[1], ob_done[2], ob_ready[1], ob_ready[2]);
    end
    model_cmd(1, 2, 32'h0);
    run_cmd(2'd1, 2, 32'h0, 2);
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL rsvd_sticky got err=%b exp=1", err);
    end
  endtask

  task automatic test_random;
    int unsigned r;
    int op, idx, n, dn;
    logic [31:0] pc;
    for (int t = 0; t < 40; t++) begin
      r   = $urandom_range(0, 9);
      op  = (r < 4) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
      idx = int'($urandom_range(0, SIZE - 1));
      pc  = $urandom;
      model_cmd(op, idx, pc);
      n  = e_addr.size();
      dn = (n == 0) ? 1 : n;
      run_cmd(2'(op), idx, pc, dn + 1);
      checks++;
      if (acc_timeout !== 1'b0) begin
        errors++; $display("FAIL rand_accept t=%0d got timeout exp accept", t);
      end
      for (int k = 1; k <= dn; k++) begin
        checks++;
        if ({ob_we[k], ob_addr[k], ob_data[k], ob_done[k], ob_ready[k], ob_busy[k]} !==
            {(k <= n), (k <= n) ? e_addr[k-1] : 32'h0, (k <= n) ? e_data[k-1] : 32'h0,
             (k == dn), 1'b0, 1'b1}) begin
          errors++;
          $display("FAIL rand_cycle t=%0d op=%0d k=%0d got we=%b a=%h d=%h done=%b rdy=%b busy=%b",
                   t, op, k, ob_we[k], ob_addr[k], ob_data[k], ob_done[k], ob_ready[k], ob_busy[k]);
        end
      end
      checks++;
      if ({ob_we[dn+1], ob_addr[dn+1], ob_data[dn+1], ob_done[dn+1], ob_ready[dn+1],
           ob_busy[dn+1], vmap, err} !== {1'b0, 64'h0, 1'b0, 1'b1, 1'b0, m_map, m_err}) begin
        errors++;
        $display("FAIL rand_end t=%0d op=%0d got we=%b done=%b rdy=%b busy=%b map=%h err=%b exp map=%h err=%b",
                 t, op, ob_we[dn+1], ob_done[dn+1], ob_ready[dn+1], ob_busy[dn+1],
                 vmap, err, m_map, m_err);
      end
    end
  endtask

  task automatic test_back_to_back;
    int acc = 0;
    int acc_cyc[0:1];
    acc_cyc[0] = 0; acc_cyc[1] = 0;
    model_cmd(0, 6, 32'h0000_6000);
    model_cmd(0, 9, 32'h0000_9000);
    cmd_op = 2'd0; cmd_idx = 4'd6; cmd_pc = 32'h0000_6000; cmd_valid = 1'b1;
    for (int c = 0; c < 30 && acc < 2; c++) begin
      checks++;
      if (busy && cmd_ready) begin
        errors++; $display("FAIL b2b_ready_busy c=%0d got rdy=1 busy=1 exp rdy=0", c);
      end
      if (cmd_ready) begin
        acc_cyc[acc] = c;
        acc++;
      end
      @(negedge clk);
      if (acc == 1) begin
        cmd_idx = 4'd9; cmd_pc = 32'h0000_9000;
      end
    end
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({acc, acc_cyc[1] - acc_cyc[0]} !== {32'd2, 32'd4}) begin
      errors++; $display("FAIL b2b_spacing got acc=%0d gap=%0d exp acc=2 gap=4",
                         acc, acc_cyc[1] - acc_cyc[0]);
    end
    checks++;
    if (vmap !== m_map) begin
      errors++; $display("FAIL b2b_map got=%h exp=%h", vmap, m_map);
    end
  endtask

  task automatic test_reset_mid;
    cmd_op = 2'd0; cmd_idx = 4'd5; cmd_pc = 32'h0000_5000; cmd_valid = 1'b1;
    for (int w = 0; w < 50 && !cmd_ready; w++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({we, done, vmap, err, cmd_ready} !== {1'b0, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL midreset_state got we=%b done=%b map=%h err=%b rdy=%b exp all 0",
                         we, done, vmap, err, cmd_ready);
    end
    rst = 1'b0;
    m_map = '0; m_err = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({we, done, busy, cmd_ready} !== 4'b0001) begin
        errors++; $display("FAIL midreset_quiet c=%0d got we=%b done=%b busy=%b rdy=%b exp 0 0 0 1",
                           c, we, done, busy, cmd_ready);
      end
    end
    model_cmd(0, 7, 32'h0000_7000);
    run_cmd(2'd0, 7, 32'h0000_7000, 4);
    checks++;
    if ({acc_timeout, vmap} !== {1'b0, 16'h0080}) begin
      errors++; $display("FAIL midreset_newcmd got timeout=%b map=%h exp 0 0080", acc_timeout, vmap);
    end
  endtask

  initial begin
    test_reset();
    test_load_invalidate();
    test_clear_all();
    test_reserved();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/skip_table_writer.md
SKIP_TABLE_WRITER -- requirements
Module: skip_table_writer

Interface
REQ-001 The block SHALL have parameter SKIP_TABLE_SIZE, default 16, the number of skip-table entries (power of two, at least 2); IW = log2(SKIP_TABLE_SIZE).
REQ-002 The block SHALL have parameter SKIP_TABLE_BLOCK_IDX, default 1, the block index placed in WriteAddressOut[31:IW+2].
REQ-003 The block SHALL have port ClockIn, input, 1 bit: the single clock.
REQ-004 The block SHALL have port ResetIn, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port CmdValidIn, input, 1 bit: command present.
REQ-006 The block SHALL have port CmdReadyOut, output, 1 bit: command accepted when high together with CmdValidIn.
REQ-007 The block SHALL have port CmdOpIn, input, 2 bits: 0 = LOAD, 1 = INVALIDATE, 2 = CLEAR_ALL, 3 = reserved.
REQ-008 The block SHALL have port CmdIdxIn, input, IW bits: target entry index.
REQ-009 The block SHALL have port CmdPCIn, input, 32 bits: PC for LOAD.
REQ-010 The block SHALL have port WriteEnOut, output, 1 bit: table write strobe.
REQ-011 The block SHALL have port WriteAddressOut, output, 32 bits: table write address.
REQ-012 The block SHALL have port WriteDataOut, output, 32 bits: table write data.
REQ-013 The block SHALL have port BusyOut, output, 1 bit: high in any state other than IDLE.
REQ-014 The block SHALL have port DoneOut, output, 1 bit: one-cycle pulse on completion of a command.
REQ-015 The block SHALL have port ErrorOut, output, 1 bit: sticky flag set by a reserved opcode.
REQ-016 The block SHALL have port ValidMapOut, output, SKIP_TABLE_SIZE bits: shadow of each entry's valid bit.

Function
REQ-017 Every write SHALL present WriteAddressOut = {SKIP_TABLE_BLOCK_IDX, idx, offset}, with idx at bits [IW+1:2] and offset at bits [1:0].
REQ-018 Offset 0 SHALL carry the PC. Offset 1 SHALL carry the valid flag in WriteDataOut[31], with WriteDataOut[30:0] = 0.
REQ-019 WriteEnOut, WriteAddressOut, WriteDataOut and DoneOut SHALL be registered outputs; a command accepted at edge T produces its first write in cycle T+1.
REQ-020 Each write SHALL last exactly one cycle. When WriteEnOut = 0, WriteAddressOut and WriteDataOut SHALL be 0.
REQ-021 CmdReadyOut SHALL be high only in IDLE and SHALL be low while ResetIn is high. On acceptance, the block SHALL latch the opcode, index and PC.
REQ-022 The FSM states SHALL be IDLE, WR_INVAL, WR_PC, WR_VALID and CLEAR.
REQ-023 LOAD SHALL transition IDLE -> WR_INVAL -> WR_PC -> WR_VALID -> IDLE, with these writes:
  - WR_INVAL: offset 1, data 0;
  - WR_PC: offset 0, data = PC;
  - WR_VALID: offset 1, data 0x8000_0000.
REQ-024 The invalidate-first ordering in LOAD is mandatory, so the fetch-side CAM never matches a half-written entry.
REQ-025 INVALIDATE SHALL transition IDLE -> WR_INVAL -> IDLE, with a single write at offset 1, data 0.
REQ-026 CLEAR_ALL SHALL remain in CLEAR for SKIP_TABLE_SIZE cycles and write offset 1, data 0, for idx 0 through SKIP_TABLE_SIZE-1 in ascending order; CmdIdxIn is ignored.
REQ-027 The CLEAR counter SHALL be IW+1 bits wide. CLEAR SHALL exit to IDLE after index SKIP_TABLE_SIZE-1, with no wrap to 0.
REQ-028 A reserved opcode SHALL be accepted, produce no write, set ErrorOut, and pulse DoneOut in T+1.
REQ-029 DoneOut SHALL pulse in the cycle of the final write of each command. CmdReadyOut SHALL rise in the following cycle, so the minimum LOAD-to-LOAD spacing is 4 cycles.
REQ-030 ValidMapOut[idx] SHALL update on the same edge that issues the corresponding valid write:
  - cleared by a write with valid = 0;
  - set by the WR_VALID write.
REQ-031 CmdValidIn without CmdReadyOut SHALL be ignored; the source holds the command until it is accepted.

Reset
REQ-032 While ResetIn is high at an edge, the block SHALL go to IDLE and clear WriteEnOut, WriteAddressOut, WriteDataOut, DoneOut, ErrorOut, BusyOut, ValidMapOut, the CLEAR counter and the latched command.
REQ-033 A reset mid-command SHALL abort the command: no further writes, and no DoneOut pulse.
REQ-034 CmdReadyOut SHALL be 1 in the first cycle after ResetIn falls.

Verification
REQ-035 LOAD, idx 3, PC 0x0000_1000, defaults, accepted at T -> the following writes and flags:
  - T+1: write 0x4D / 0x0;
  - T+2: write 0x4C / 0x1000;
  - T+3: write 0x4D / 0x8000_0000 with DoneOut = 1;
  - after T+3: ValidMapOut = 0x0008;
  - T+4: CmdReadyOut = 1.
REQ-036 With ValidMapOut = 0x0008, INVALIDATE idx 3 -> a single write 0x4D / 0x0 at T+1 with DoneOut = 1, then ValidMapOut = 0x0000.
REQ-037 CLEAR_ALL after LOADs to idx 0 and 15 -> 16 consecutive writes at addresses 0x41, 0x45, ... 0x7D, all with data 0; DoneOut on the 16th; ValidMapOut = 0; no 17th write.
REQ-038 CmdValidIn held high with two queued LOADs -> acceptances exactly 4 cycles apart, and CmdReadyOut low during BusyOut.
REQ-039 ResetIn asserted in the WR_PC cycle of a LOAD -> next cycle WriteEnOut = 0, DoneOut never pulses, ValidMapOut = 0, and a new command is accepted after ResetIn falls.
REQ-040 Opcode 3 -> no WriteEnOut, DoneOut pulse at T+1, ErrorOut = 1 held until ResetIn.
